// File: rtl/seq101_pkg.sv
// Shared encodings for the "101" sequence detector and its word-level scan controller.
package seq101_pkg;

    typedef enum logic [1:0] {
        DET_S0 = 2'd0,
        DET_S1 = 2'd1,
        DET_S2 = 2'd2
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ctrl_state_t;

    localparam logic [2:0] PATTERN = 3'b101;

endpackage

// File: rtl/seq101_det.sv
// Overlapping "101" Mealy detector with synchronous clear and advance enable.
//   state  | meaning
//   DET_S0 | no useful prefix seen
//   DET_S1 | last bit was 1
//   DET_S2 | last two bits were 10
module seq101_det
    import seq101_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    input  logic in,
    output logic y
);

    det_state_t state;
    det_state_t state_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= DET_S0;
        end else if (clr) begin
            state <= DET_S0;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // y is qualified by en so an idle detector never reports a match
    always_comb begin
        state_nxt = state;
        y         = 1'b0;
        if (en) begin
            case (state)
                DET_S0: state_nxt = (in == PATTERN[2]) ? DET_S1 : DET_S0;
                DET_S1: state_nxt = (in == PATTERN[1]) ? DET_S2 : DET_S1;
                DET_S2: begin
                    if (in == PATTERN[0]) begin
                        state_nxt = DET_S1;
                        y         = 1'b1;
                    end else begin
                        state_nxt = DET_S0;
                    end
                end
                default: state_nxt = DET_S0;
            endcase
        end
    end

endmodule

// File: rtl/seq101_scan_ctrl.sv
// Word-level scan controller: serialises words MSB-first into seq101_det and reports per-word match statistics.
//   state | meaning
//   IDLE  | waiting for a word (in_ready=1)
//   SHIFT | feeding one bit per clock into the detector
//   DONE  | result held on out_* until out_ready
module seq101_scan_ctrl
    import seq101_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int TOT_W = 16,
    localparam int CW    = $clog2(W + 1),
    localparam int PW    = $clog2(W)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_hit,
    output logic [PW-1:0]    out_first_pos,
    output logic [TOT_W-1:0] total_hits
);

    ctrl_state_t    state;
    ctrl_state_t    state_nxt;
    logic [W-1:0]   shreg;
    logic [PW-1:0]  bit_idx;
    logic [CW-1:0]  count;
    logic [PW-1:0]  first_pos;
    logic           accept;
    logic           last_bit;
    logic           det_en;
    logic           det_clr;
    logic           det_y;

    assign last_bit = (bit_idx == PW'(W - 1));
    assign det_clr  = accept && !in_chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        det_en    = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                det_en = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    seq101_det u_det (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (det_clr),
        .en      (det_en),
        .in      (shreg[W-1]),
        .y       (det_y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg     <= '0;
            bit_idx   <= '0;
            count     <= '0;
            first_pos <= '0;
        end else if (accept) begin
            shreg     <= in_data;
            bit_idx   <= '0;
            count     <= '0;
            first_pos <= '0;
        end else if (det_en) begin
            shreg   <= {shreg[W-2:0], 1'b0};
            bit_idx <= bit_idx + PW'(1);
            if (det_y) begin
                count <= count + CW'(1);
                if (count == '0) begin
                    first_pos <= bit_idx;
                end
            end
        end
    end

    // Running total sticks at all-ones rather than wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            total_hits <= '0;
        end else if (det_y && (total_hits != '1)) begin
            total_hits <= total_hits + TOT_W'(1);
        end
    end

    assign out_count     = count;
    assign out_hit       = (count != '0);
    assign out_first_pos = first_pos;

endmodule

// File: tb/tb_seq101_scan_ctrl.sv
// Scoreboard bench for seq101_scan_ctrl; a second instance with a 3-bit total exercises saturation.
module tb_seq101_scan_ctrl;

    localparam int W      = 8;
    localparam int TOT_W  = 16;
    localparam int TOT_WB = 3;
    localparam int CW     = $clog2(W + 1);
    localparam int PW     = $clog2(W);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              reset_n_b;
    logic              in_valid;
    logic [W-1:0]      in_data;
    logic              in_chain;
    logic              out_ready;

    logic              in_ready,  in_ready_b;
    logic              out_valid, out_valid_b;
    logic [CW-1:0]     out_count, out_count_b;
    logic              out_hit,   out_hit_b;
    logic [PW-1:0]     out_first_pos, out_first_pos_b;
    logic [TOT_W-1:0]  total_hits;
    logic [TOT_WB-1:0] total_hits_b;

    always #5 clk = ~clk;

    seq101_scan_ctrl #(.W(W), .TOT_W(TOT_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_chain(in_chain), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_hit(out_hit), .out_first_pos(out_first_pos),
        .total_hits(total_hits)
    );

    seq101_scan_ctrl #(.W(W), .TOT_W(TOT_WB)) dut_b (
        .clk(clk), .reset_n(reset_n_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_chain(in_chain), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_count(out_count_b), .out_hit(out_hit_b), .out_first_pos(out_first_pos_b),
        .total_hits(total_hits_b)
    );

    typedef struct {
        int cnt;
        int first;
        int total;
        int total_b;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] hist;
    int         hist_n;
    int         m_total;
    int         m_total_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: sliding window over the bit stream, history dropped when not chained
    function automatic void model_push(input logic [W-1:0] d, input logic c);
        exp_t e;
        logic b;
        e.cnt = 0;
        e.first = 0;
        if (!c) hist_n = 0;
        for (int i = 0; i < W; i++) begin
            b = d[W-1-i];
            if (hist_n >= 2 && hist == 2'b10 && b) begin
                if (e.cnt == 0) e.first = i;
                e.cnt++;
            end
            hist = {hist[0], b};
            if (hist_n < 2) hist_n++;
        end
        m_total   = (m_total + e.cnt > 65535) ? 65535 : m_total + e.cnt;
        m_total_b = (m_total_b + e.cnt > 7) ? 7 : m_total_b + e.cnt;
        e.total   = m_total;
        e.total_b = m_total_b;
        sb.push_back(e);
    endfunction

    task automatic send(input logic [W-1:0] d, input logic c);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_chain = c;
        @(posedge clk);
        model_push(d, c);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit chk_b, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, W);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("out_count", out_count, e.cnt);
            check("out_hit", out_hit, (e.cnt != 0));
            check("out_first_pos", out_first_pos, e.first);
            check("total_hits", total_hits, e.total);
            if (chk_b) begin
                check("b_out_valid", out_valid_b, 1);
                check("b_out_count", out_count_b, e.cnt);
                check("b_total_hits", total_hits_b, e.total_b);
            end
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = 8'hFF;
                in_chain = 1'b0;
                @(posedge clk);
                #1;
                check("bp_out_valid", out_valid, 1);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_count", out_count, e.cnt);
                check("bp_first_pos", out_first_pos, e.first);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hs_out_valid", out_valid, 0);
        check("hs_in_ready", in_ready, 1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        reset_n_b = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_chain  = 1'b0;
        out_ready = 1'b0;
        hist      = 2'b00;
        hist_n    = 0;
        m_total   = 0;
        m_total_b = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_hit", out_hit, 0);
        check("rst_first_pos", out_first_pos, 0);
        check("rst_total", total_hits, 0);
        check("rst_b_total", total_hits_b, 0);
        @(negedge clk);
        reset_n = 1'b1;

        send(8'b1010_1010, 1'b0);  collect(0, 0);
        send(8'h00, 1'b0);         collect(0, 0);
        send(8'b0000_0010, 1'b0);  collect(0, 0);
        send(8'b1000_0000, 1'b1);  collect(0, 0);
        send(8'b0000_0010, 1'b0);  collect(0, 0);
        send(8'b1000_0000, 1'b0);  collect(0, 0);
        send(8'b1011_0101, 1'b0);  collect(0, 5);

        for (int i = 0; i < 6; i++) begin
            send(W'($urandom), 1'($urandom_range(0, 1)));
            collect(0, 0);
        end

        send(8'hAA, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_total", total_hits, 0);
        sb.delete();
        hist_n  = 0;
        m_total = 0;
        @(negedge clk);
        reset_n = 1'b1;
        send(8'b1000_0000, 1'b1);  collect(0, 0);

        @(negedge clk);
        reset_n_b = 1'b1;
        m_total_b = 0;
        for (int i = 0; i < 3; i++) begin
            send(8'hAA, 1'b0);
            collect(1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq101_scan_ctrl.md
# seq101_scan_ctrl

Word-level controller for the overlapping "101" Mealy sequence detector. It accepts parallel words over a valid/ready handshake and serialises each word MSB-first into an embedded detector, one bit per clock. It then reports the number of matches and the position of the first match over a second valid/ready handshake. It sits between a word-oriented producer (bus/FIFO) and any consumer of match statistics, and owns the detector's clear/advance sequencing, including optional state chaining across words.

## Interface
- W, default 8: data word width, ≥ 3.
- TOT_W, default 16: width of the running match total.
- CW, localparam $clog2(W+1): per-word count width.
- PW, localparam $clog2(W): position width.
- clk  input  1  clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  word available.
- in_ready  output  1  controller can accept a word; equals (state==IDLE).
- in_data  input  W  word; bit W-1 is serialised first.
- in_chain  input  1  sampled with the word: 1 = keep detector state from the previous word, 0 = clear detector to S0 first.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_count  output  CW  matches detected in this word.
- out_hit  output  1  out_count != 0.
- out_first_pos  output  PW  serial index (0 = first bit shifted) of the first match; 0 when out_hit=0.
- total_hits  output  TOT_W  saturating count of all matches since reset.

## Operation
- FSM states:
  - IDLE → SHIFT on in_valid && in_ready.
  - SHIFT → DONE after the W-th bit.
  - DONE → IDLE on out_ready.
  - Illegal encodings → IDLE.
- Accept (IDLE, in_valid=1):
  - shreg ← in_data; bit_idx ← 0; count ← 0; first_pos ← 0.
  - If in_chain=0, pulse the detector clr so its state is S0 before the first bit.
- SHIFT, each cycle:
  - Detector en=1 with input shreg[W-1].
  - shreg shifts left; bit_idx increments.
  - If the detector's Mealy output y=1 in that cycle:
    - count increments.
    - If count was 0, first_pos ← bit_idx.
    - total_hits increments, saturating at 2^TOT_W−1.
- Detector semantics: overlapping "101"; after a match the state is S1. With en=0 the state holds, and y is forced to 0.
- DONE: out_valid=1. out_count, out_hit and out_first_pos are registered and held stable until the handshake. in_valid is ignored.
- Count bound: at most ceil(W/2) matches, which always fits CW. No overflow is possible.
- Reset (any state, including mid-SHIFT or DONE):
  - FSM → IDLE; detector → S0; shreg, counters and total_hits → 0.
  - out_valid=0, in_ready=1.
  - The partially shifted word is discarded with no output.
- Chaining applies only to the word immediately following a completed word. After reset, in_chain=1 behaves as 0 because the detector is already at S0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_count=0, out_hit=0, out_first_pos=0, total_hits=0.
- Accept at edge E0. Bits are consumed at edges E0+1 … E0+W. out_valid rises after edge E0+W.
- Result handshake at edge E1 (out_valid && out_ready). in_ready=1 after E1. Earliest next accept is at edge E1+1.
- Throughput: one word per W+2 cycles when the consumer is always ready.
- out_ready high outside DONE has no effect. There are no combinational paths input → output except in_ready/out_valid from the state register.
- total_hits updates on the same edge as the match bit.

## Structure
- Shared package seq101_pkg holds:
  - detector state encodings S0/S1/S2;
  - controller state encodings IDLE/SHIFT/DONE;
  - the pattern constant 3'b101.
- One sub-module, seq101_det:
  - ports: clk, reset_n, clr, en, in, y;
  - Mealy detector with synchronous clr and enable;
  - instantiated once.
- Everything else (shift register, counters, FSM) lives in seq101_scan_ctrl.

## Test plan
- W=8, in_data=8'b1010_1010, in_chain=0 → out_count=3, out_hit=1, out_first_pos=2, total_hits=3; out_valid rises 8 cycles after accept.
- in_data=8'h00 → out_count=0, out_hit=0, out_first_pos=0; total_hits unchanged.
- Chaining:
  - 8'b0000_0010 (count 0), then 8'b1000_0000 with in_chain=1 → count 1, first_pos 0.
  - Repeat the pair with in_chain=0 on the second word → count 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 → out_valid stays 1, outputs stable, in_ready=0, no word accepted. Release → in_ready=1 on the next cycle.
- Reset mid-operation: assert reset_n=0 after 3 bits of 8'hAA → out_valid=0, in_ready=1, total_hits=0 immediately. Next word 8'b1000_0000 with in_chain=1 → count 0.
- TOT_W=3: three words of 8'hAA → total_hits 3, 6, then 7 (saturated); each out_count=3.
